// File: rtl/mem_defs.sv
// Shared memory-subsystem definitions: geometry and the common FSM state encoding
// used by both the transfer FSM and the readback checker.
package mem_defs;

   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 8;
   localparam int NUM_WORDS = 1024;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through output; dout reads 0 when empty.
module sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [DATA_W-1:0]        din,
   output logic [DATA_W-1:0]        dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PW-1:0]     r_wr_ptr;
   logic [PW-1:0]     r_rd_ptr;
   logic [PW:0]       r_count;
   logic              w_push;
   logic              w_pop;

   assign empty  = (r_count == '0);
   assign full   = (r_count == (PW+1)'(DEPTH));
   assign count  = r_count;
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;
   assign dout   = empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= din;
   end

endmodule

// File: rtl/mem_readback.sv
// Reads back the output RAM after a transfer, compares each byte with the input ROM,
// accumulates error/checksum results and streams the RAM bytes out over valid/ready.
module mem_readback #(
   parameter int ADDR_W     = mem_defs::ADDR_W,
   parameter int DATA_W     = mem_defs::DATA_W,
   parameter int NUM_WORDS  = mem_defs::NUM_WORDS,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_dout,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_dout,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic [15:0]       checksum
);

   import mem_defs::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W:0]   r_addr;
   logic [ADDR_W-1:0] r_land_addr;
   logic              r_inflight;
   logic [ADDR_W:0]   r_err_count;
   logic [ADDR_W-1:0] r_first_err;
   logic [15:0]       r_checksum;

   logic [CW-1:0]     w_fifo_count;
   logic              w_fifo_empty;
   logic              w_fifo_full;
   logic              w_issue;
   logic              w_last;
   logic              w_clear;
   logic              w_pop;
   logic              w_drained;

   // Credit excludes the same-cycle pop, so the FIFO can never be pushed while full.
   assign w_issue   = (r_state == S_READ) &&
                      ((int'(r_inflight) + int'(w_fifo_count)) < FIFO_DEPTH);
   assign w_last    = (r_addr == (ADDR_W+1)'(NUM_WORDS - 1));
   assign w_clear   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_pop     = m_valid && m_ready;
   // Look ahead one pop so done rises in the first cycle the FIFO is actually empty.
   assign w_drained = !r_inflight &&
                      (w_fifo_empty || ((w_fifo_count == CW'(1)) && w_pop));

   assign ram_addr       = r_addr[ADDR_W-1:0];
   assign rom_addr       = r_addr[ADDR_W-1:0];
   assign m_valid        = !w_fifo_empty;
   assign busy           = (r_state == S_READ) || (r_state == S_DRAIN);
   assign done           = (r_state == S_DONE);
   assign err_count      = r_err_count;
   assign first_err_addr = r_first_err;
   assign checksum       = r_checksum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_READ;
         S_READ:  if (w_issue && w_last) w_next = S_DRAIN;
         S_DRAIN: if (w_drained) w_next = S_DONE;
         S_DONE:  if (start) w_next = S_READ;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr      <= '0;
         r_land_addr <= '0;
         r_inflight  <= 1'b0;
         r_err_count <= '0;
         r_first_err <= '0;
         r_checksum  <= '0;
      end else begin
         r_inflight <= w_issue;
         if (w_clear) begin
            r_addr      <= '0;
            r_err_count <= '0;
            r_first_err <= '0;
            r_checksum  <= '0;
         end else begin
            if (w_issue) begin
               r_addr      <= r_addr + 1'b1;
               r_land_addr <= r_addr[ADDR_W-1:0];
            end
            if (r_inflight) begin
               r_checksum <= r_checksum + 16'(ram_dout);
               if (ram_dout != rom_dout) begin
                  r_err_count <= r_err_count + 1'b1;
                  if (r_err_count == '0) r_first_err <= r_land_addr;
               end
            end
         end
      end
   end

   sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (r_inflight),
      .pop   (w_pop),
      .din   (ram_dout),
      .dout  (m_data),
      .count (w_fifo_count),
      .empty (w_fifo_empty),
      .full  (w_fifo_full)
   );

   logic w_unused;
   assign w_unused = w_fifo_full;

endmodule

// File: tb/tb_mem_readback.sv
// Directed bench for mem_readback: RAM/ROM models, stream capture, result and timing checks.
module tb_mem_readback;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [9:0]  ram_addr, rom_addr;
   logic [7:0]  ram_dout = 8'h00, rom_dout = 8'h00;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic        busy, done;
   logic [10:0] err_count;
   logic [9:0]  first_err_addr;
   logic [15:0] checksum;

   logic [7:0]  ram_mem [1024];
   logic [7:0]  rom_mem [1024];
   logic [7:0]  got [$];

   int checks = 0, failures = 0;
   int stab_viol = 0, overlap = 0, addr_viol = 0, credit_viol = 0;
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;

   mem_readback dut (
      .clk(clk), .reset(reset), .start(start),
      .ram_addr(ram_addr), .ram_dout(ram_dout),
      .rom_addr(rom_addr), .rom_dout(rom_dout),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .busy(busy), .done(done), .err_count(err_count),
      .first_err_addr(first_err_addr), .checksum(checksum)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ram_dout <= ram_mem[ram_addr];
      rom_dout <= rom_mem[rom_addr];
   end

   always @(negedge clk) begin
      if (reset) begin
         if (m_valid && m_ready) got.push_back(m_data);
         if (prev_stall && m_data !== prev_data) stab_viol++;
         if (busy && done) overlap++;
         if (rom_addr !== ram_addr) addr_viol++;
         if (busy && (int'(ram_addr) - got.size()) > 4) credit_viol++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_stream(input string tag);
      int bad;
      bad = 0;
      chk({tag, "_len"}, got.size(), 1024);
      foreach (got[i]) if (i < 1024 && got[i] !== ram_mem[i]) bad++;
      chk({tag, "_bytes"}, bad, 0);
   endtask

   // mode 0: ready=1, 1: random 30% ready, 2: ready low 50 cycles, 3: ready=1 + start pulse in READ
   task automatic do_run(input int mode, output int cyc);
      got.delete();
      cyc = 0;
      @(posedge clk); #1;
      start   = 1'b1;
      m_ready = (mode == 2) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (mode == 1) m_ready = ($urandom_range(0, 9) < 3);
      while (cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            chk("busy_after_start", busy, 1'b1);
            chk("done_after_start", done, 1'b0);
         end
         if (mode == 2 && cyc == 50) begin
            chk("stall_ram_addr", ram_addr, 10'd4);
            chk("stall_valid", m_valid, 1'b1);
            chk("stall_head", m_data, 8'h00);
            chk("stall_no_pop", got.size(), 0);
         end
         if (done) break;
         @(posedge clk); #1;
         case (mode)
            1: m_ready = ($urandom_range(0, 9) < 3);
            2: m_ready = (cyc >= 50);
            3: start = (cyc == 100);
            default: m_ready = 1'b1;
         endcase
      end
      chk("done_reached", done, 1'b1);
      start   = 1'b0;
      m_ready = 1'b1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ram_addr"}, ram_addr, 10'd0);
      chk({tag, "_rom_addr"}, rom_addr, 10'd0);
      chk({tag, "_valid"}, m_valid, 1'b0);
      chk({tag, "_data"}, m_data, 8'h00);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_err"}, err_count, 11'd0);
      chk({tag, "_first"}, first_err_addr, 10'd0);
      chk({tag, "_csum"}, checksum, 16'h0000);
   endtask

   initial begin
      int cyc;
      int w;
      for (int i = 0; i < 1024; i++) begin
         ram_mem[i] = 8'(i);
         rom_mem[i] = 8'(i);
      end

      repeat (3) @(negedge clk);
      chk_reset_vals("reset");
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("post_reset");

      // Clean run, full throughput
      do_run(0, cyc);
      chk("clean_done_cycle", cyc, 1027);
      chk("clean_err", err_count, 11'd0);
      chk("clean_first", first_err_addr, 10'd0);
      chk("clean_csum", checksum, 16'hFE00);
      chk_stream("clean");

      // Two corrupted RAM bytes; start issued from DONE
      ram_mem[5]   = 8'hAA;
      ram_mem[900] = 8'h00;
      do_run(0, cyc);
      chk("err_done_cycle", cyc, 1027);
      chk("err_count", err_count, 11'd2);
      chk("err_first", first_err_addr, 10'd5);
      chk("err_csum", checksum, 16'hFE21);
      chk("err_byte5", (got.size() > 5) ? got[5] : 8'hxx, 8'hAA);
      chk_stream("err");
      ram_mem[5]   = 8'd5;
      ram_mem[900] = 8'd132;

      // Random backpressure
      do_run(1, cyc);
      chk("rand_err", err_count, 11'd0);
      chk("rand_csum", checksum, 16'hFE00);
      chk_stream("rand");

      // Long initial stall
      do_run(2, cyc);
      chk("stall_err", err_count, 11'd0);
      chk("stall_csum", checksum, 16'hFE00);
      chk_stream("stall");

      // start pulse during READ must be ignored
      do_run(3, cyc);
      chk("ign_done_cycle", cyc, 1027);
      chk("ign_csum", checksum, 16'hFE00);
      chk_stream("ign");

      // Reset mid-run at byte 300
      got.delete();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      w = 0;
      while (got.size() < 300 && w < 5000) begin
         @(posedge clk); #1;
         w++;
      end
      chk("midrun_reached_300", got.size() >= 300, 1'b1);
      reset = 1'b0;
      @(negedge clk);
      chk_reset_vals("midrun_reset");
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk_reset_vals("midrun_release");
      do_run(0, cyc);
      chk("rerun_done_cycle", cyc, 1027);
      chk("rerun_err", err_count, 11'd0);
      chk("rerun_csum", checksum, 16'hFE00);
      chk_stream("rerun");

      chk("stable_while_stalled", stab_viol, 0);
      chk("busy_done_overlap", overlap, 0);
      chk("rom_eq_ram_addr", addr_viol, 0);
      chk("outstanding_le_4", credit_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
